// File: rtl/bram_stream_capture.sv
// bram_stream_capture: stream-to-BRAM frame writer.
// Each accepted beat is written to consecutive BRAM addresses starting at 0.
// The buffer is held after tlast until release_i frees it.
// Beats past BRAM_DEPTH are accepted and dropped, and the overflow flag is set.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast - sample stream slave
//   bram_addr/bram_wdata/bram_we      - registered BRAM write port
//   frame_done          - completed frame is held
//   frame_len           - words written for the last completed frame
//   overflow            - last frame exceeded BRAM_DEPTH beats
//   release_i           - frees the held buffer (the name "release" is a keyword)
module bram_stream_capture #(
    parameter int unsigned BRAM_DEPTH      = 32,
    parameter int unsigned BRAM_DATA_WIDTH = 32,
    localparam int unsigned AW             = $clog2(BRAM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BRAM_DATA_WIDTH-1:0] s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic                       s_tlast,
    output logic [AW-1:0]              bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_wdata,
    output logic                       bram_we,
    output logic                       frame_done,
    output logic [AW:0]                frame_len,
    output logic                       overflow,
    input  logic                       release_i
);

    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DROP    = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic                       we_q, we_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [BRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [LW-1:0]              len_q, len_d;
    logic                       ovf_q, ovf_d;
    logic                       beat;
    logic                       ptr_last;

    // Handshake and status decoded straight from the state register
    assign s_tready   = (state_q != ST_DONE);
    assign frame_done = (state_q == ST_DONE);
    assign beat       = s_tvalid && s_tready;
    assign ptr_last   = (wr_ptr_q == AW'(BRAM_DEPTH - 1));

    // State register and registered BRAM/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_CAPTURE;
            wr_ptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        len_d    = len_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            ST_CAPTURE: begin
                if (beat) begin
                    we_d    = 1'b1;
                    addr_d  = wr_ptr_q;
                    wdata_d = s_tdata;
                    // Hold at the last address so the pointer never wraps in a frame
                    wr_ptr_d = ptr_last ? wr_ptr_q : wr_ptr_q + AW'(1);
                    if (s_tlast) begin
                        len_d   = LW'(wr_ptr_q) + LW'(1);
                        state_d = ST_DONE;
                    end else if (ptr_last) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (beat && s_tlast) begin
                    len_d   = LW'(BRAM_DEPTH);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (release_i) begin
                    wr_ptr_d = '0;
                    ovf_d    = 1'b0;
                    state_d  = ST_CAPTURE;
                end
            end
            default: state_d = ST_CAPTURE;
        endcase
    end

    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign frame_len  = len_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bram_stream_capture.sv
// Testbench for bram_stream_capture: scoreboard of expected BRAM writes,
// plus frame status checks after each frame.
module tb_bram_stream_capture;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic          bram_we;
    logic          frame_done;
    logic [AW:0]   frame_len;
    logic          overflow;
    logic          release_i;

    bram_stream_capture #(
        .BRAM_DEPTH     (DEPTH),
        .BRAM_DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .bram_addr (bram_addr),
        .bram_wdata(bram_wdata),
        .bram_we   (bram_we),
        .frame_done(frame_done),
        .frame_len (frame_len),
        .overflow  (overflow),
        .release_i (release_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  writes = 0;
    int  m_ptr  = 0;
    bit  m_drop = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every observed write must match the head of the expected queue
    always @(negedge clk) begin
        wr_t e;
        if (rst === 1'b0 && bram_we === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bram_addr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(bram_addr), 64'(e.addr));
                check("wr_data", 64'(bram_wdata), 64'(e.data));
            end
        end
    end

    // Called at a negedge; presents one beat for one edge and updates the model
    task automatic drive_beat(input logic [DW-1:0] d, input bit last);
        check("tready_before_beat", 64'(s_tready), 64'd1);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        if (!m_drop) begin
            exp_q.push_back('{addr: AW'(m_ptr), data: d});
            if (!last && m_ptr == int'(DEPTH) - 1) m_drop = 1'b1;
            m_ptr++;
        end
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after the tlast beat returns
    task automatic end_frame(input string name, input int exp_len, input bit exp_ovf, input int exp_writes);
        #1;
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_writes"}, 64'(writes), 64'(exp_writes));
        check({name, "_done"}, 64'(frame_done), 64'd1);
        check({name, "_tready"}, 64'(s_tready), 64'd0);
        check({name, "_len"}, 64'(frame_len), 64'(exp_len));
        check({name, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        @(negedge clk);
    endtask

    task automatic rearm();
        release_i = 1'b1;
        @(negedge clk);
        release_i = 1'b0;
        check("rearm_tready", 64'(s_tready), 64'd1);
        check("rearm_done", 64'(frame_done), 64'd0);
        check("rearm_ovf", 64'(overflow), 64'd0);
        m_ptr  = 0;
        m_drop = 1'b0;
        writes = 0;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_we"}, 64'(bram_we), 64'd0);
        check({name, "_addr"}, 64'(bram_addr), 64'd0);
        check({name, "_wdata"}, 64'(bram_wdata), 64'd0);
        check({name, "_done"}, 64'(frame_done), 64'd0);
        check({name, "_len"}, 64'(frame_len), 64'd0);
        check({name, "_ovf"}, 64'(overflow), 64'd0);
        check({name, "_tready"}, 64'(s_tready), 64'd1);
    endtask

    initial begin
        rst       = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        release_i = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_values("por");
        idle(3);
        rst = 1'b0;
        idle(1);
        check("post_reset_tready", 64'(s_tready), 64'd1);

        // Nominal: 5 back-to-back beats
        for (int i = 0; i < 5; i++) drive_beat(DW'(32'hA0 + i), i == 4);
        end_frame("nominal", 5, 1'b0, 5);

        // Held buffer: valid asserted, nothing must be accepted or written
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_tready", 64'(s_tready), 64'd0);
            check("hold_done", 64'(frame_done), 64'd1);
        end
        s_tvalid = 1'b0;
        check("hold_writes", 64'(writes), 64'd5);
        rearm();

        // Gapped: 2 idle cycles between beats
        for (int i = 0; i < 3; i++) begin
            drive_beat(DW'($urandom), i == 2);
            if (i != 2) idle(2);
        end
        end_frame("gapped", 3, 1'b0, 3);
        rearm();

        // Exact fill
        for (int i = 0; i < int'(DEPTH); i++) drive_beat(DW'($urandom), i == int'(DEPTH) - 1);
        end_frame("exact", int'(DEPTH), 1'b0, int'(DEPTH));
        rearm();

        // Overflow: 40 beats, only DEPTH written
        for (int i = 0; i < 40; i++) begin
            drive_beat(DW'($urandom), i == 39);
            if (i == int'(DEPTH)) check("drop_ovf", 64'(overflow), 64'd1);
        end
        end_frame("overflow", int'(DEPTH), 1'b1, int'(DEPTH));
        rearm();

        // Two-beat frame with a release pulse mid-frame that must be ignored
        drive_beat(32'h1111_0000, 1'b0);
        release_i = 1'b1;
        @(negedge clk);
        release_i = 1'b0;
        check("cap_release_done", 64'(frame_done), 64'd0);
        drive_beat(32'h1111_0001, 1'b1);
        end_frame("rearm2", 2, 1'b0, 2);
        rearm();

        // Asynchronous reset mid-frame
        drive_beat(32'h2222_0000, 1'b0);
        drive_beat(32'h2222_0001, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst    = 1'b0;
        m_ptr  = 0;
        m_drop = 1'b0;
        writes = 0;
        idle(2);
        check("midrst_no_done", 64'(frame_done), 64'd0);
        check("midrst_sb_empty", 64'(exp_q.size()), 64'd0);

        // Single-beat frame after reset
        drive_beat(32'h3333_3333, 1'b1);
        end_frame("single", 1, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
